id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage placed directly downstream of the register file's two combinational read ports (rd1/rd2).
- Resolves RAW hazards by bypassing from EX, MEM and WB. The WB path covers the register file's posedge write not being visible in the same cycle.
- Detects load-use hazards, stalls decode and inserts a bubble.
- Registers operands, immediate and control fields into the EX stage.

Parameters:
- XLEN, 32, operand/data width.
- CTRL_W, 16, width of the opaque decoded-control bundle passed to EX.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  decode slot holds a valid instruction.
- id_rs1_i, id_rs2_i  in  5  source register indices (same values driven to regfile ra1/ra2).
- id_use_rs1_i, id_use_rs2_i  in  1  instruction actually reads rs1/rs2.
- id_rd_i  in  5  destination register index.
- id_we_i  in  1  instruction writes rd.
- id_is_load_i  in  1  instruction is a load.
- id_imm_i  in  XLEN  decoded immediate.
- id_ctrl_i  in  CTRL_W  decoded control bundle.
- rf_rd1_i, rf_rd2_i  in  XLEN  register file read data.
- ex_result_i  in  XLEN  combinational ALU result of the instruction currently in EX.
- ex_ready_i  in  1  EX accepts a new instruction this cycle.
- mem_rd_i  in  5  MEM stage destination index.
- mem_we_i  in  1  MEM stage register write enable.
- mem_result_i  in  XLEN  final MEM result, including load data.
- wb_rd_i  in  5  WB destination index (same as regfile wa3).
- wb_we_i  in  1  WB write enable (same as we3).
- wb_wd_i  in  XLEN  WB data (same as wd3).
- flush_i  in  1  kill the instruction in decode; EX receives a bubble.
- id_stall_o  out  1  decode must hold its current instruction.
- ex_valid_o  out  1  EX register holds a valid instruction.
- ex_op_a_o, ex_op_b_o  out  XLEN  resolved rs1/rs2 values.
- ex_imm_o  out  XLEN  registered immediate.
- ex_rd_o  out  5  registered destination index.
- ex_we_o  out  1  registered write enable, qualified by valid.
- ex_is_load_o  out  1  registered load flag, qualified by valid.
- ex_ctrl_o  out  CTRL_W  registered control bundle.

Behaviour:
- Reset (async, rst_n=0):
  - All ex_* outputs are 0; ex_valid_o=0.
  - id_stall_o is combinational and reads 0 while the EX register is empty and ex_ready_i=1.
- Bypass select, per operand, with x0 never matching:
  - Priority: EX (ex_valid_o & ex_we_o & !ex_is_load_o & ex_rd_o==rs) first.
  - Then MEM (mem_we_i & mem_rd_i==rs).
  - Then WB (wb_we_i & wb_rd_i==rs).
  - Otherwise rf_rd*_i.
  - rs==0 always yields 0, whatever the source data.
- Load-use hazard:
  - load_use = id_valid_i & ex_valid_o & ex_is_load_o & ex_rd_o!=0 & ((id_use_rs1_i & rs1==ex_rd_o) | (id_use_rs2_i & rs2==ex_rd_o)).
- id_stall_o = (load_use | !ex_ready_i) & !flush_i.
- EX register update each clock:
  - !ex_ready_i: hold all EX registers, including flush_i cycles.
  - ex_ready_i & flush_i: ex_valid_o<=0 and ex_we_o/ex_is_load_o<=0. Flush wins over load_use.
  - ex_ready_i & load_use: bubble as above; decode holds. Next cycle the load is in MEM and its data bypasses via MEM.
  - ex_ready_i otherwise: capture the decode slot with valid=id_valid_i; we/is_load are ANDed with id_valid_i.
- Latency: one cycle, decode to EX outputs.
- Bubble contents: ex_op_*/imm/rd/ctrl may hold stale data when ex_valid_o=0; ex_we_o and ex_is_load_o must be 0.
- Reset mid-operation immediately clears the EX register, discarding any in-flight instruction.

Optional Feature:
- STALL_PERF_EN defined:
  - Adds output stall_cnt_o [31:0] counting cycles with load_use & ex_ready_i & !flush_i.
  - Saturates at 0xFFFF_FFFF; reset to 0.
- Undefined: port and counter absent; no other behavioural change.

Decomposition:
- riscv_pkg holds:
  - XLEN, REG_IDX_W=5.
  - Typedef fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
  - CTRL_W default.
- One natural sub-module: operand_fwd_mux, a combinational priority select for a single operand. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- EX forward: EX holds addi x5 with ex_result_i=0x10; decode add x6,x5,x5 -> next cycle ex_op_a_o=ex_op_b_o=0x10.
- Priority: MEM writes x7=0xAA and WB writes x7=0xBB, rf=0xCC -> operand=0xAA. With MEM off -> 0xBB. With both off -> 0xCC.
- x0 guard: wb_we_i=1, wb_rd_i=0, wb_wd_i=0xDEAD, rs1=0 -> ex_op_a_o=0.
- Load-use: lw x3 in EX, decode add x4,x3,x1 -> id_stall_o=1 for one cycle and an ex_valid_o=0 bubble. Next cycle the add enters with op_a=mem_result_i (0x1234).
- Flush + load_use in the same cycle -> id_stall_o=0 and EX receives a bubble. With ex_ready_i=0 for 3 cycles -> EX outputs are held unchanged and id_stall_o=1.
- Async reset asserted mid-stream with ex_valid_o=1 -> all outputs 0 without waiting for a clock edge. With STALL_PERF_EN, stall_cnt_o=0 after reset and increments by exactly 1 per load-use bubble.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths, forwarding-source encoding and the hit helper used by the
// decode-to-execute operand stage.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 16;

    // Operand source, in ascending priority order.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    // A producer stage matches a source index only when it writes that
    // register; x0 is hardwired and never matches.
    function automatic logic fwd_hit(input logic                 we,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs);
        return we && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority bypass select for a single source operand: EX, then MEM, then WB,
// then register file. x0 always reads as zero.
module operand_fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [riscv_pkg::REG_IDX_W-1:0] rs,
    input  logic                            ex_fwd_en,
    input  logic [riscv_pkg::REG_IDX_W-1:0] ex_rd,
    input  logic [XLEN-1:0]                 ex_result,
    input  logic                            mem_we,
    input  logic [riscv_pkg::REG_IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]                 mem_result,
    input  logic                            wb_we,
    input  logic [riscv_pkg::REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]                 wb_wd,
    input  logic [XLEN-1:0]                 rf_data,
    output logic [XLEN-1:0]                 operand
);
    import riscv_pkg::*;

    fwd_sel_e sel;

    // Pick the youngest producer of rs.
    always_comb begin
        sel = FWD_RF;
        if (fwd_hit(ex_fwd_en, ex_rd, rs))
            sel = FWD_EX;
        else if (fwd_hit(mem_we, mem_rd, rs))
            sel = FWD_MEM;
        else if (fwd_hit(wb_we, wb_rd, rs))
            sel = FWD_WB;
    end

    // Steer the selected data; x0 is forced to zero regardless of rf contents.
    always_comb begin
        operand = rf_data;
        case (sel)
            FWD_EX:  operand = ex_result;
            FWD_MEM: operand = mem_result;
            FWD_WB:  operand = wb_wd;
            default: operand = rf_data;
        endcase
        if (rs == '0)
            operand = '0;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: RAW bypass from EX/MEM/WB, load-use stall
// with bubble insertion, and the ID/EX pipeline register.
// Optional: define STALL_PERF_EN to add stall_cnt_o, a saturating count of
// load-use bubble cycles.
module id_ex_operand_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int CTRL_W = riscv_pkg::CTRL_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            id_valid_i,
    input  logic [riscv_pkg::REG_IDX_W-1:0] id_rs1_i,
    input  logic [riscv_pkg::REG_IDX_W-1:0] id_rs2_i,
    input  logic                            id_use_rs1_i,
    input  logic                            id_use_rs2_i,
    input  logic [riscv_pkg::REG_IDX_W-1:0] id_rd_i,
    input  logic                            id_we_i,
    input  logic                            id_is_load_i,
    input  logic [XLEN-1:0]                 id_imm_i,
    input  logic [CTRL_W-1:0]               id_ctrl_i,
    input  logic [XLEN-1:0]                 rf_rd1_i,
    input  logic [XLEN-1:0]                 rf_rd2_i,
    input  logic [XLEN-1:0]                 ex_result_i,
    input  logic                            ex_ready_i,
    input  logic [riscv_pkg::REG_IDX_W-1:0] mem_rd_i,
    input  logic                            mem_we_i,
    input  logic [XLEN-1:0]                 mem_result_i,
    input  logic [riscv_pkg::REG_IDX_W-1:0] wb_rd_i,
    input  logic                            wb_we_i,
    input  logic [XLEN-1:0]                 wb_wd_i,
    input  logic                            flush_i,
    output logic                            id_stall_o,
    output logic                            ex_valid_o,
    output logic [XLEN-1:0]                 ex_op_a_o,
    output logic [XLEN-1:0]                 ex_op_b_o,
    output logic [XLEN-1:0]                 ex_imm_o,
    output logic [riscv_pkg::REG_IDX_W-1:0] ex_rd_o,
    output logic                            ex_we_o,
    output logic                            ex_is_load_o,
    output logic [CTRL_W-1:0]               ex_ctrl_o
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]                     stall_cnt_o
`endif
);
    import riscv_pkg::*;

    logic            ex_fwd_en;
    logic            load_use;
    logic            bubble;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    // A load in EX has no data yet, so it is excluded from EX bypass and
    // handled by the load-use stall instead.
    assign ex_fwd_en = ex_valid_o & ex_we_o & ~ex_is_load_o;

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .rs         (id_rs1_i),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (ex_rd_o),
        .ex_result  (ex_result_i),
        .mem_we     (mem_we_i),
        .mem_rd     (mem_rd_i),
        .mem_result (mem_result_i),
        .wb_we      (wb_we_i),
        .wb_rd      (wb_rd_i),
        .wb_wd      (wb_wd_i),
        .rf_data    (rf_rd1_i),
        .operand    (op_a)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .rs         (id_rs2_i),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (ex_rd_o),
        .ex_result  (ex_result_i),
        .mem_we     (mem_we_i),
        .mem_rd     (mem_rd_i),
        .mem_result (mem_result_i),
        .wb_we      (wb_we_i),
        .wb_rd      (wb_rd_i),
        .wb_wd      (wb_wd_i),
        .rf_data    (rf_rd2_i),
        .operand    (op_b)
    );

    // Load-use detection and decode stall; a flush kills decode so never stalls.
    always_comb begin
        load_use = id_valid_i & ex_valid_o & ex_is_load_o & (ex_rd_o != '0) &
                   ((id_use_rs1_i & (id_rs1_i == ex_rd_o)) |
                    (id_use_rs2_i & (id_rs2_i == ex_rd_o)));
        id_stall_o = (load_use | ~ex_ready_i) & ~flush_i;
        bubble     = flush_i | load_use;
    end

    // ID/EX register: hold when EX is busy, bubble on flush or load-use,
    // otherwise capture decode. Payload is left stale inside a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o   <= 1'b0;
            ex_op_a_o    <= '0;
            ex_op_b_o    <= '0;
            ex_imm_o     <= '0;
            ex_rd_o      <= '0;
            ex_we_o      <= 1'b0;
            ex_is_load_o <= 1'b0;
            ex_ctrl_o    <= '0;
        end else if (ex_ready_i) begin
            if (bubble) begin
                ex_valid_o   <= 1'b0;
                ex_we_o      <= 1'b0;
                ex_is_load_o <= 1'b0;
            end else begin
                ex_valid_o   <= id_valid_i;
                ex_op_a_o    <= op_a;
                ex_op_b_o    <= op_b;
                ex_imm_o     <= id_imm_i;
                ex_rd_o      <= id_rd_i;
                ex_we_o      <= id_we_i & id_valid_i;
                ex_is_load_o <= id_is_load_i & id_valid_i;
                ex_ctrl_o    <= id_ctrl_i;
            end
        end
    end

`ifdef STALL_PERF_EN
    // Saturating count of cycles that actually inserted a load-use bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_o <= '0;
        else if (load_use && ex_ready_i && !flush_i && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule
